// File: rtl/count_control.sv
// Upstream control for the up/down counter pair: synchronises and debounces the
// Run and Swap buttons, keeps the run/stop state and issues Enable/Swap strobes.
module count_control #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic Clock,
  input  logic Reset,
  input  logic BtnRun,
  input  logic BtnSwap,
  output logic Enable,
  output logic Swap,
  output logic Running
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  // Bit 0 carries Run, bit 1 carries Swap through every stage.
  logic [1:0]    btn;
  logic [1:0]    sync_p0, sync_p1;
  logic [1:0]    deb_p2, deb_p3, press_p3;
  logic [CW-1:0] cnt_p2 [2];
  logic [PW-1:0] presc;
  logic          run_press, swap_pending, tick, stop;

  assign btn          = {BtnSwap, BtnRun};
  assign run_press    = press_p3[0];
  assign swap_pending = press_p3[1];
  assign tick         = Running && (presc == PRE_LAST);
  assign stop         = run_press && Running;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      deb_p2   <= '0;
      deb_p3   <= '0;
      press_p3 <= '0;
      for (int i = 0; i < 2; i++) cnt_p2[i] <= '0;
      presc    <= '0;
      Running  <= 1'b0;
      Enable   <= 1'b0;
      Swap     <= 1'b0;
    end else begin
      // p0/p1: two-flop synchroniser
      sync_p0 <= btn;
      sync_p1 <= sync_p0;

      // p2: debounce, a new level must differ for DEBOUNCE_CYCLES samples in a row
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          deb_p2[i] <= sync_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CW'(1);
        end
      end

      // p3: one-cycle press pulse on the debounced rising edge
      deb_p3   <= deb_p2;
      press_p3 <= deb_p2 & ~deb_p3;

      // outputs: a swap cycle absorbs a coinciding tick, a stopping press drops it
      Running <= Running ^ run_press;
      if (run_press || !Running || presc == PRE_LAST) presc <= '0;
      else                                            presc <= presc + PW'(1);
      Enable  <= swap_pending | (tick & ~stop);
      Swap    <= swap_pending;
    end
  end

endmodule

// File: tb/tb_count_control.sv
// Randomised and directed bench for count_control against an edge-indexed
// reference model of button acceptance, run/stop state and strobe scheduling.
module tb_count_control;

  localparam int D   = 4;
  localparam int T   = 8;
  localparam int LAT = D + 3;

  logic Clock = 1'b0;
  logic Reset, BtnRun, BtnSwap;
  logic Enable, Swap, Running;

  count_control #(.DEBOUNCE_CYCLES(D), .TICK_DIV(T)) dut (
    .Clock(Clock), .Reset(Reset), .BtnRun(BtnRun), .BtnSwap(BtnSwap),
    .Enable(Enable), .Swap(Swap), .Running(Running)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Model: raw samples seen two edges late, debounced level, action edge per button.
  bit m_r1 [2];
  bit m_r2 [2];
  bit m_deb [2];
  int m_diff [2];
  int m_act [2];
  bit m_running;
  int m_start;
  bit exp_en, exp_sw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst, input bit br, input bit bs);
    bit cur [2];
    bit runev, swev, tickdue, v;
    cur[0] = br;
    cur[1] = bs;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_r1[b] = 0; m_r2[b] = 0; m_deb[b] = 0; m_diff[b] = 0; m_act[b] = -1;
      end
      m_running = 0;
      m_start   = 0;
      exp_en    = 0;
      exp_sw    = 0;
    end else begin
      runev   = (m_act[0] == edge_n);
      swev    = (m_act[1] == edge_n);
      tickdue = m_running && (edge_n > m_start) && ((edge_n - m_start) % T == 0);
      exp_sw  = swev;
      exp_en  = swev || (tickdue && !(runev && m_running));
      if (runev) begin
        m_running = !m_running;
        m_start   = edge_n;
      end
      for (int b = 0; b < 2; b++) begin
        v = m_r2[b];
        m_r2[b] = m_r1[b];
        m_r1[b] = cur[b];
        if (v != m_deb[b]) begin
          m_diff[b]++;
          if (m_diff[b] == D) begin
            m_deb[b]  = v;
            m_diff[b] = 0;
            if (v) m_act[b] = edge_n + 2;
          end
        end else begin
          m_diff[b] = 0;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit br, input bit bs);
    Reset   = rst;
    BtnRun  = br;
    BtnSwap = bs;
    @(posedge Clock);
    edge_n++;
    model_update(rst, br, bs);
    #1;
    chk("enable", Enable, exp_en);
    chk("swap", Swap, exp_sw);
    chk("running", Running, m_running);
  endtask

  initial begin
    int s0, t, len, dn, up, tmp, nsw;
    bit rb, sb, rr;

    // Reset with both buttons held
    for (int i = 0; i < 3; i++) step(1, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0);
    chk("reset_idle_running", Running, 0);

    // Run press: latency and periodic enables
    s0 = edge_n + 1;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0);
      if (edge_n == s0 + LAT - 1) chk("run_lat_before", Running, 0);
      if (edge_n == s0 + LAT)     chk("run_lat", Running, 1);
      if (edge_n == s0 + LAT + T) chk("first_enable", Enable, 1);
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("run_held_after_release", Running, 1);

    // Swap timed so its strobe lands on a tick
    t = m_start + T;
    while (t - LAT < edge_n + 1) t += T;
    while (edge_n + 1 < t - LAT) step(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1);
      if (edge_n == t) chk("collide_swap", Swap, 1);
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      if (edge_n == t + T) chk("after_collide_enable", Enable, 1);
    end

    // Second run press stops counting
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("stopped", Running, 0);

    // Bounce shorter than the debounce window
    for (int i = 0; i < 30; i++) step(0, (i / 2) % 2 == 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0);
    chk("bounce_running", Running, 0);

    // Swap while stopped exchanges downstream counters exactly once
    dn = 15; up = 0; nsw = 0;
    for (int i = 0; i < 25; i++) begin
      step(0, 0, i < 10);
      if (Enable && Swap) begin
        tmp = dn; dn = up; up = tmp; nsw++;
      end
    end
    chk("swap_count", nsw, 1);
    chk("down_after_swap", dn, 0);
    chk("up_after_swap", up, 15);

    // Reset while running with a swap pending
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("running_before_reset", Running, 1);
    for (int i = 0; i < LAT; i++) step(0, 0, 1);
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    chk("reset_mid_running", Running, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0);

    // Random button activity with occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      rb  = bit'($urandom_range(0, 1));
      sb  = bit'($urandom_range(0, 1));
      len = $urandom_range(1, 25);
      rr  = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < len; k++) step(rr && k == 0, rb, sb);
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
